// File: rtl/oled_bcd_display.sv
// Frame sequencer: renders an N-digit BCD value as 6x8 glyphs on one OLED page,
// streaming page/column commands then glyph bytes over a send/done byte handshake.
module oled_bcd_display #(
  parameter int N_DIGITS = 9,
  parameter int X0       = 10,
  parameter int PAGE     = 2,
  parameter int BLANK_LZ = 1,
  parameter int AUTO_UPD = 1,
  parameter int REFRESH  = 5_000_000
) (
  input  logic                    clkin_50m,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  input  logic                    update,
  output logic                    spi_send,
  output logic [7:0]              spi_data,
  output logic                    spi_dc,
  input  logic                    spi_done,
  output logic                    busy,
  output logic                    frame_done,
  output logic [2:0]              dbg_state
);

  // Handshake: spi_send pulses for one cycle with spi_data/spi_dc valid; those
  // stay stable until spi_master answers with a one-cycle spi_done. spi_done
  // seen outside WAIT is ignored.

  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int TW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [6:0]    X0_B     = 7'(X0);
  localparam logic [2:0]    PAGE_B   = 3'(PAGE);
  localparam logic [DW-1:0] LAST_DIG = DW'(N_DIGITS - 1);

  typedef enum logic [2:0] {IDLE, CMD_PG, CMD_CL, CMD_CH, DATA, WAIT} state_t;

  state_t                r_state;
  state_t                r_ret;
  logic                  r_last;
  logic [4*N_DIGITS-1:0] r_snap;
  logic [4*N_DIGITS-1:0] r_shown;
  logic                  r_pending;
  logic [TW-1:0]         r_timer;
  logic [DW-1:0]         r_dig;
  logic [2:0]            r_col;
  logic                  r_send;
  logic [7:0]            r_data;
  logic                  r_dc;
  logic                  r_busy;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_trig;
  logic                  w_start;
  logic [3:0]            w_nib;
  logic [4*N_DIGITS-1:0] w_upper;
  logic                  w_blank;
  logic [7:0]            w_byte;

  function automatic logic [7:0] f_glyph(input logic [3:0] nib, input logic [2:0] col);
    logic [47:0] row;
    case (nib)
      4'd0:    row = 48'h38_44_44_44_38_00;
      4'd1:    row = 48'h00_48_7C_40_00_00;
      4'd2:    row = 48'h48_64_64_54_4C_00;
      4'd3:    row = 48'h28_44_4C_4C_34_00;
      4'd4:    row = 48'h10_28_24_7C_20_00;
      4'd5:    row = 48'h3C_54_54_54_34_00;
      4'd6:    row = 48'h38_54_54_54_30_00;
      4'd7:    row = 48'h0C_04_74_0C_04_00;
      4'd8:    row = 48'h2C_54_54_54_6C_00;
      4'd9:    row = 48'h18_54_54_54_38_00;
      default: row = 48'h08_08_08_08_08_00;
    endcase
    row = row << {col, 3'b000};
    return row[47:40];
  endfunction

  assign w_tick  = (REFRESH > 0) && (r_timer == TW'(REFRESH - 1));
  assign w_trig  = update || ((AUTO_UPD != 0) && (bcd_in != r_shown)) || w_tick;
  assign w_start = (r_state == IDLE) && en && (w_trig || r_pending);

  // A digit is blank when it and everything above it is zero (never digit 0).
  assign w_nib   = r_snap[{r_dig, 2'b00} +: 4];
  assign w_upper = r_snap >> {r_dig, 2'b00};
  assign w_blank = (BLANK_LZ != 0) && (r_dig != '0) && (w_upper == '0);
  assign w_byte  = w_blank ? 8'h00 : f_glyph(w_nib, r_col);

  always_ff @(posedge clkin_50m) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ret        <= IDLE;
      r_last       <= 1'b0;
      r_snap       <= '0;
      r_shown      <= '1;
      r_pending    <= 1'b0;
      r_timer      <= '0;
      r_dig        <= LAST_DIG;
      r_col        <= 3'd0;
      r_send       <= 1'b0;
      r_data       <= 8'h00;
      r_dc         <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_send       <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_tick || (REFRESH <= 1)) r_timer <= '0;
      else                          r_timer <= r_timer + 1'b1;

      if (w_trig && !w_start) r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_snap    <= bcd_in;
            r_shown   <= bcd_in;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_dig     <= LAST_DIG;
            r_col     <= 3'd0;
            r_state   <= CMD_PG;
          end
        end
        CMD_PG: begin
          r_send  <= 1'b1;
          r_data  <= {5'b10110, PAGE_B};
          r_dc    <= 1'b0;
          r_last  <= 1'b0;
          r_ret   <= CMD_CL;
          r_state <= WAIT;
        end
        CMD_CL: begin
          r_send  <= 1'b1;
          r_data  <= {4'h0, X0_B[3:0]};
          r_dc    <= 1'b0;
          r_ret   <= CMD_CH;
          r_state <= WAIT;
        end
        CMD_CH: begin
          r_send  <= 1'b1;
          r_data  <= {5'b00010, X0_B[6:4]};
          r_dc    <= 1'b0;
          r_ret   <= DATA;
          r_state <= WAIT;
        end
        DATA: begin
          r_send  <= 1'b1;
          r_data  <= w_byte;
          r_dc    <= 1'b1;
          r_ret   <= DATA;
          r_last  <= (r_dig == '0) && (r_col == 3'd5);
          r_state <= WAIT;
          if (r_col == 3'd5) begin
            r_col <= 3'd0;
            r_dig <= r_dig - 1'b1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        WAIT: begin
          if (spi_done) begin
            if (r_last) begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_state <= r_ret;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi_send   = r_send;
  assign spi_data   = r_data;
  assign spi_dc     = r_dc;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_oled_bcd_display.sv
// Bench for oled_bcd_display: two instances (blanking/auto-update and periodic refresh),
// spi_master responders, and a scoreboard fed by a byte-level display model.
module tb_oled_bcd_display;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [47:0] glyph_row(input logic [3:0] nib);
    case (nib)
      4'd0: return 48'h384444443800;
      4'd1: return 48'h00487C400000;
      4'd2: return 48'h48646454_4C00;
      4'd3: return 48'h28444C4C3400;
      4'd4: return 48'h1028247C2000;
      4'd5: return 48'h3C5454543400;
      4'd6: return 48'h385454543000;
      4'd7: return 48'h0C04740C0400;
      4'd8: return 48'h2C5454546C00;
      4'd9: return 48'h185454543800;
      default: return 48'h080808080800;
    endcase
  endfunction

  // Byte k of a frame as {dc, data}.
  function automatic logic [8:0] model_byte(input logic [63:0] val, input int n, input int x0,
                                            input int page, input int blz, input int k);
    int j, d, c;
    logic [63:0] hi;
    logic [47:0] row;
    if (k == 0) return {1'b0, 8'(8'hB0 + page)};
    if (k == 1) return {1'b0, 8'(x0 % 16)};
    if (k == 2) return {1'b0, 8'(16 + x0 / 16)};
    j  = k - 3;
    d  = n - 1 - j / 6;
    c  = j % 6;
    hi = val >> (4 * d);
    if (blz != 0 && d != 0 && hi == 64'd0) return 9'h100;
    row = glyph_row(hi[3:0]) >> (8 * (5 - c));
    return {1'b1, row[7:0]};
  endfunction

  // ---------------- instance A: 9 digits, blanking, auto update ----------------
  logic        rst_a, en_a, upd_a, a_send, a_dc, a_done, a_busy, a_fd;
  logic [35:0] bcd_a;
  logic [7:0]  a_data;
  logic [2:0]  a_st;
  logic [8:0]  exp_a[$];
  int          a_sends = 0, a_frames = 0, a_lat = 4;

  oled_bcd_display #(.N_DIGITS(9), .X0(10), .PAGE(2), .BLANK_LZ(1), .AUTO_UPD(1), .REFRESH(0)) u_a (
    .clkin_50m(clk), .reset(rst_a), .en(en_a), .bcd_in(bcd_a), .update(upd_a),
    .spi_send(a_send), .spi_data(a_data), .spi_dc(a_dc), .spi_done(a_done),
    .busy(a_busy), .frame_done(a_fd), .dbg_state(a_st)
  );

  task automatic push_frame_a(input logic [35:0] v);
    for (int k = 0; k < 57; k++) exp_a.push_back(model_byte({28'd0, v}, 9, 10, 2, 1, k));
  endtask

  // ---------------- instance B: 4 digits, no blanking, periodic refresh ----------------
  logic        rst_b, en_b, b_send, b_dc, b_done, b_busy, b_fd;
  logic [15:0] bcd_b;
  logic [7:0]  b_data;
  logic [2:0]  b_st;
  int          b_sends = 0, b_frames = 0, b_idx = 0, b_prev = -1;
  logic        b_period_on = 1'b1;

  oled_bcd_display #(.N_DIGITS(4), .X0(100), .PAGE(5), .BLANK_LZ(0), .AUTO_UPD(0), .REFRESH(300)) u_b (
    .clkin_50m(clk), .reset(rst_b), .en(en_b), .bcd_in(bcd_b), .update(1'b0),
    .spi_send(b_send), .spi_data(b_data), .spi_dc(b_dc), .spi_done(b_done),
    .busy(b_busy), .frame_done(b_fd), .dbg_state(b_st)
  );

  // ---------------- spi_master responders ----------------
  logic [8:0] a_sent;
  int         a_l;
  logic       a_abort;
  initial begin
    a_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_a && a_send) begin
        a_sent  = {a_dc, a_data};
        a_l     = (a_lat == 0) ? int'($urandom_range(1, 6)) : a_lat;
        a_abort = 1'b0;
        for (int i = 1; i < a_l; i++) begin
          @(negedge clk);
          if (rst_a) begin a_abort = 1'b1; break; end
        end
        if (!a_abort && !rst_a) begin
          check("a_hold_stable", {a_dc, a_data}, a_sent);
          a_done = 1'b1;
          @(negedge clk);
          a_done = 1'b0;
        end
      end
    end
  end

  logic [8:0] b_sent;
  initial begin
    b_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_b && b_send) begin
        b_sent = {b_dc, b_data};
        repeat (3) @(negedge clk);
        check("b_hold_stable", {b_dc, b_data}, b_sent);
        b_done = 1'b1;
        @(negedge clk);
        b_done = 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_a) begin
      if (a_send) begin
        a_sends++;
        check("a_busy_at_send", a_busy, 1);
        if (exp_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected_send got=%0h exp=none t=%0t", {a_dc, a_data}, $time);
        end else begin
          check("a_byte", {a_dc, a_data}, exp_a.pop_front());
        end
      end
      if (a_fd) a_frames++;
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (b_send) begin
        check("b_byte", {b_dc, b_data}, model_byte({48'd0, bcd_b}, 4, 100, 5, 0, b_idx));
        b_idx = (b_idx + 1) % 27;
        b_sends++;
      end
      if (b_fd) begin
        b_frames++;
        check("b_frame_len", b_idx, 0);
        if (b_period_on && b_prev >= 0) check("b_refresh_period", cyc - b_prev, 300);
        b_prev = cyc;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_frames_a(input int n);
    int t, cnt;
    t = a_frames + n;
    cnt = 0;
    while (a_frames < t && cnt < 6000) begin @(negedge clk); cnt++; end
    check("a_frames_reached", a_frames, t);
    repeat (2) @(negedge clk);
    check("a_queue_drained", exp_a.size(), 0);
  endtask

  task automatic wait_sends_a(input int n);
    int t, cnt;
    t = a_sends + n;
    cnt = 0;
    while (a_sends < t && cnt < 3000) begin @(negedge clk); cnt++; end
    check("a_sends_reached", a_sends >= t, 1);
  endtask

  task automatic pulse_upd_a();
    upd_a = 1'b1;
    @(negedge clk);
    upd_a = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [35:0] v;
  int          f, s, nd;
  initial begin
    rst_a = 1'b1; en_a = 1'b0; upd_a = 1'b0; bcd_a = 36'h000012345;
    rst_b = 1'b1; en_b = 1'b0; bcd_b = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_spi_send", a_send, 0);
    check("rst_spi_data", a_data, 0);
    check("rst_spi_dc", a_dc, 0);
    check("rst_busy", a_busy, 0);
    check("rst_frame_done", a_fd, 0);
    check("rst_b_send", b_send, 0);
    check("rst_b_busy", b_busy, 0);
    rst_a = 1'b0; rst_b = 1'b0; en_b = 1'b1;

    // en low: the auto trigger (shown reset to all F) only latches pending
    repeat (20) @(negedge clk);
    check("en_low_no_send", a_sends, 0);
    check("en_low_idle", a_busy, 0);

    // en rising starts the pending frame: B2 0A 10, 24 blanks, glyphs 1..5
    push_frame_a(bcd_a);
    en_a = 1'b1;
    wait_frames_a(1);
    check("frame1_sends", a_sends, 57);
    check("frame1_done_count", a_frames, 1);

    // forced redraw; en dropping mid-frame must not abort it
    a_lat = 0;
    push_frame_a(bcd_a);
    pulse_upd_a();
    wait_sends_a(5);
    en_a = 1'b0;
    wait_frames_a(1);
    check("frame2_sends", a_sends, 114);
    en_a = 1'b1;
    repeat (10) @(negedge clk);
    check("no_redraw_unchanged", a_sends, 114);

    // all zero: 48 blank bytes then the "0" glyph
    bcd_a = 36'h000000000;
    push_frame_a(bcd_a);
    wait_frames_a(1);

    // dash digit stops leading blanking
    bcd_a = 36'h00000C012;
    push_frame_a(bcd_a);
    wait_frames_a(1);

    // three changes during one frame collapse into one redraw of the final value
    bcd_a = 36'h000000777;
    push_frame_a(bcd_a);
    wait_sends_a(8);
    bcd_a = 36'h000001111;
    wait_sends_a(15);
    bcd_a = 36'h000222222;
    wait_sends_a(20);
    bcd_a = 36'h987654321;
    push_frame_a(bcd_a);
    wait_frames_a(2);
    f = a_frames;
    repeat (300) @(negedge clk);
    check("no_extra_frame", a_frames, f);

    // random values, mixing zeros and the occasional A..F nibble
    for (int r = 0; r < 8; r++) begin
      v  = '0;
      nd = $urandom_range(1, 9);
      for (int d = 0; d < nd; d++) begin
        if ($urandom_range(0, 7) == 0) v[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      bcd_a = v;
      push_frame_a(v);
      pulse_upd_a();
      wait_frames_a(1);
    end

    // reset while waiting on a data byte abandons the frame
    a_lat = 6;
    push_frame_a(bcd_a);
    pulse_upd_a();
    wait_sends_a(12);
    rst_a = 1'b1;
    f = a_frames;
    @(negedge clk);
    check("midrst_send", a_send, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_frame_done", a_fd, 0);
    exp_a.delete();
    repeat (3) @(negedge clk);
    check("midrst_no_done", a_frames, f);
    push_frame_a(bcd_a);
    rst_a = 1'b0;
    wait_frames_a(1);

    // B: en low blocks periodic starts; en rising starts the pending frame
    b_period_on = 1'b0;
    en_b = 1'b0;
    repeat (200) @(negedge clk);
    f = b_frames;
    repeat (500) @(negedge clk);
    check("b_en_low_blocks", b_frames, f);
    s = b_sends;
    en_b = 1'b1;
    repeat (4) @(negedge clk);
    check("b_pending_start", b_sends > s, 1);
    repeat (400) @(negedge clk);
    check("b_frames_seen", b_frames > 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
